// File: rtl/playback_sequencer.sv
// Song playback sequencer: fetches note words from song memory and plays each for its decoded beat count.
// Optional build macro PLAYBACK_LOOP_EN adds a `loop` input that restarts the song at its end marker.
//
// state    | meaning
// S_IDLE   | waiting for start (also entered on stop or handshake timeout)
// S_REWIND | mem_read_rst pulse, rewinds memory read pointer
// S_FETCH  | mem_read_en pulse, timeout counter cleared
// S_WAIT   | waiting for mem_ready, bounded by TIMEOUT_TICKS
// S_DECODE | split captured word into note and duration
// S_PLAY   | pitch on note_out for the decoded number of beats
// S_GAP    | articulation silence before the next fetch
// S_DONE   | end marker reached, waiting for start
module playback_sequencer #(
  parameter int DATA_WIDTH     = 8,
  parameter int SEL_WIDTH      = 2,
  parameter int TICKS_PER_BEAT = 25_000_000,
  parameter int GAP_TICKS      = 2_500_000,
  parameter int TIMEOUT_TICKS  = 1024,
  parameter int END_CODE       = 31
) (
  input  logic                  clk,
  input  logic                  rst,
`ifdef PLAYBACK_LOOP_EN
  input  logic                  loop,
`endif
  input  logic                  start,
  input  logic                  stop,
  input  logic                  pause,
  input  logic [SEL_WIDTH-1:0]  song_sel,
  output logic [SEL_WIDTH-1:0]  mem_select,
  output logic                  mem_read_rst,
  output logic                  mem_read_en,
  input  logic [DATA_WIDTH-1:0] mem_data,
  input  logic                  mem_ready,
  output logic [4:0]            note_out,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout_err
);

  localparam int DUR_W    = DATA_WIDTH - 5;
  localparam int TICK_MAX = (TICKS_PER_BEAT > GAP_TICKS) ? TICKS_PER_BEAT : GAP_TICKS;
  localparam int TICK_W   = $clog2(TICK_MAX + 1);
  localparam int TO_W     = $clog2(TIMEOUT_TICKS + 1);

  localparam logic [TICK_W-1:0] BEAT_LAST = TICK_W'(TICKS_PER_BEAT - 1);
  localparam logic [TICK_W-1:0] GAP_LAST  = TICK_W'(GAP_TICKS - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_TICKS - 1);
  localparam logic [4:0]        END_NOTE  = 5'(END_CODE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REWIND,
    S_FETCH,
    S_WAIT,
    S_DECODE,
    S_PLAY,
    S_GAP,
    S_DONE
  } state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] note_word;
  logic [TICK_W-1:0]     tick_cnt;
  logic [DUR_W-1:0]      beat_cnt;
  logic [TO_W-1:0]       to_cnt;
  logic                  loop_req;
  logic                  active;

`ifdef PLAYBACK_LOOP_EN
  assign loop_req = loop;
`else
  assign loop_req = 1'b0;
`endif

  assign active = (state != S_IDLE) && (state != S_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      mem_select   <= '0;
      mem_read_rst <= 1'b0;
      mem_read_en  <= 1'b0;
      note_out     <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      timeout_err  <= 1'b0;
      note_word    <= '0;
      tick_cnt     <= '0;
      beat_cnt     <= '0;
      to_cnt       <= '0;
    end else begin
      mem_read_rst <= 1'b0;
      mem_read_en  <= 1'b0;
      done         <= 1'b0;

      if (stop && active) begin
        state    <= S_IDLE;
        note_out <= '0;
        busy     <= 1'b0;
        tick_cnt <= '0;
        beat_cnt <= '0;
        to_cnt   <= '0;
      end else begin
        case (state)
          S_IDLE, S_DONE: begin
            if (start && !stop) begin
              mem_select   <= song_sel;
              timeout_err  <= 1'b0;
              mem_read_rst <= 1'b1;
              busy         <= 1'b1;
              state        <= S_REWIND;
            end
          end

          S_REWIND: begin
            mem_read_en <= 1'b1;
            state       <= S_FETCH;
          end

          S_FETCH: begin
            to_cnt <= '0;
            state  <= S_WAIT;
          end

          // A ready arriving on the final allowed cycle still wins over the timeout.
          S_WAIT: begin
            if (mem_ready) begin
              note_word <= mem_data;
              state     <= S_DECODE;
            end else if (to_cnt == TO_LAST) begin
              timeout_err <= 1'b1;
              note_out    <= '0;
              busy        <= 1'b0;
              to_cnt      <= '0;
              state       <= S_IDLE;
            end else begin
              to_cnt <= to_cnt + 1'b1;
            end
          end

          S_DECODE: begin
            if (note_word[4:0] == END_NOTE) begin
              note_out <= '0;
              done     <= 1'b1;
              if (loop_req) begin
                mem_read_rst <= 1'b1;
                state        <= S_REWIND;
              end else begin
                busy  <= 1'b0;
                state <= S_DONE;
              end
            end else begin
              note_out <= note_word[4:0];
              tick_cnt <= '0;
              beat_cnt <= '0;
              state    <= S_PLAY;
            end
          end

          // beat_cnt runs 0..duration code, giving duration+1 beats.
          S_PLAY: begin
            if (!pause) begin
              if (tick_cnt == BEAT_LAST) begin
                tick_cnt <= '0;
                if (beat_cnt == note_word[DATA_WIDTH-1:5]) begin
                  beat_cnt <= '0;
                  note_out <= '0;
                  state    <= S_GAP;
                end else begin
                  beat_cnt <= beat_cnt + 1'b1;
                end
              end else begin
                tick_cnt <= tick_cnt + 1'b1;
              end
            end
          end

          S_GAP: begin
            if (!pause) begin
              if (tick_cnt == GAP_LAST) begin
                tick_cnt    <= '0;
                mem_read_en <= 1'b1;
                state       <= S_FETCH;
              end else begin
                tick_cnt <= tick_cnt + 1'b1;
              end
            end
          end

          default: begin
            note_out <= '0;
            busy     <= 1'b0;
            state    <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_playback_sequencer.sv
// Self-checking bench for playback_sequencer with a behavioural song memory and a timeline reference model.
module tb_playback_sequencer;

  localparam int TPB = 4;
  localparam int GAP = 2;
  localparam int TMO = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       stop;
  logic       pause;
  logic [1:0] song_sel;
  logic [1:0] mem_select;
  logic       mem_read_rst;
  logic       mem_read_en;
  logic [7:0] mem_data;
  logic       mem_ready;
  logic [4:0] note_out;
  logic       busy;
  logic       done;
  logic       timeout_err;
`ifdef PLAYBACK_LOOP_EN
  logic       loop;
`endif

  always #5 clk = ~clk;

  playback_sequencer #(
    .DATA_WIDTH(8),
    .SEL_WIDTH(2),
    .TICKS_PER_BEAT(TPB),
    .GAP_TICKS(GAP),
    .TIMEOUT_TICKS(TMO),
    .END_CODE(31)
  ) dut (
    .clk(clk),
    .rst(rst),
`ifdef PLAYBACK_LOOP_EN
    .loop(loop),
`endif
    .start(start),
    .stop(stop),
    .pause(pause),
    .song_sel(song_sel),
    .mem_select(mem_select),
    .mem_read_rst(mem_read_rst),
    .mem_read_en(mem_read_en),
    .mem_data(mem_data),
    .mem_ready(mem_ready),
    .note_out(note_out),
    .busy(busy),
    .done(done),
    .timeout_err(timeout_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Song memory: mem_lat cycles after a read_en pulse, one ready cycle with the next word; 0 = never ready.
  logic [7:0] songs [4][8];
  int mem_lat;
  int ptr;
  int pend;

  initial begin
    mem_ready = 1'b0;
    mem_data  = 8'h00;
    ptr       = 0;
    pend      = 0;
    forever begin
      @(negedge clk);
      mem_ready = 1'b0;
      mem_data  = 8'($urandom);
      if (mem_read_rst) begin
        ptr  = 0;
        pend = 0;
      end
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          mem_ready = 1'b1;
          mem_data  = (ptr < 8) ? songs[mem_select][ptr] : 8'h1F;
          ptr++;
        end
      end
      if (mem_read_en && mem_lat > 0) pend = mem_lat;
    end
  end

  typedef struct packed {
    logic [4:0] note;
    logic       bsy;
    logic       dn;
    logic       rrst;
    logic       ren;
  } obs_t;

  obs_t exp_q[$];

  function automatic void push(input logic [4:0] n, input logic b, input logic d,
                               input logic r, input logic e, input int cnt);
    for (int k = 0; k < cnt; k++) exp_q.push_back(obs_t'{n, b, d, r, e});
  endfunction

  // Expected per-cycle outputs from the first cycle after the start edge, from the documented latencies.
  function automatic void build_expected(input int sel, input int n, input int lat);
    logic [7:0] w;
    exp_q.delete();
    push(5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1);
    push(5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1);
    push(5'd0, 1'b1, 1'b0, 1'b0, 1'b0, lat + 1);
    for (int j = 0; j < n; j++) begin
      w = songs[sel][j];
      push(w[4:0], 1'b1, 1'b0, 1'b0, 1'b0, (int'(w[7:5]) + 1) * TPB);
      push(5'd0, 1'b1, 1'b0, 1'b0, 1'b0, GAP);
      push(5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1);
      push(5'd0, 1'b1, 1'b0, 1'b0, 1'b0, lat + 1);
    end
    push(5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1);
    push(5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2);
  endfunction

  task automatic pulse_start(input logic [1:0] sel);
    song_sel = sel;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    song_sel = 2'($urandom);
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  typedef struct {
    logic [7:0] word;
    int         lat;
    logic [1:0] sel;
    logic [4:0] exp_note;
    int         exp_first;
    int         exp_len;
    int         exp_done;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int   first, len, done_at, n_done, pc, busy_low;
    logic [4:0] seen;
    logic pset, found, bad, to_seen;
    obs_t obs;

    vecs[0] = '{8'h4A, 1, 2'd2, 5'd10, 5, 12, 22};
    vecs[1] = '{8'h03, 2, 2'd1, 5'd3,  6, 4,  16};
    vecs[2] = '{8'h1F, 1, 2'd0, 5'd0,  0, 0,  5};
    vecs[3] = '{8'hE0, 1, 2'd3, 5'd0,  0, 0,  42};
    vecs[4] = '{8'hFE, 3, 2'd0, 5'd30, 7, 32, 46};
    vecs[5] = '{8'h1E, 1, 2'd1, 5'd30, 5, 4,  14};
    vecs[6] = '{8'h21, 2, 2'd3, 5'd1,  6, 8,  20};

    for (int s = 0; s < 4; s++)
      for (int j = 0; j < 8; j++) songs[s][j] = 8'h1F;

    rst      = 1'b1;
    start    = 1'b0;
    stop     = 1'b0;
    pause    = 1'b0;
    song_sel = 2'd0;
    mem_lat  = 1;
`ifdef PLAYBACK_LOOP_EN
    loop     = 1'b0;
`endif

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst note_out", 32'(note_out), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst timeout_err", 32'(timeout_err), 32'd0);
    check("rst mem_select", 32'(mem_select), 32'd0);
    check("rst mem_read_rst", 32'(mem_read_rst), 32'd0);
    check("rst mem_read_en", 32'(mem_read_en), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single-note songs: decode, latency, length and end-of-song timing.
    for (int v = 0; v < 7; v++) begin
      songs[vecs[v].sel][0] = vecs[v].word;
      songs[vecs[v].sel][1] = 8'h1F;
      mem_lat = vecs[v].lat;
      pulse_start(vecs[v].sel);
      first = 0; len = 0; done_at = 0; n_done = 0; seen = 5'd0;
      for (int c = 1; c <= 80; c++) begin
        if (c == 1) begin
          check($sformatf("vec%0d mem_select", v), 32'(mem_select), 32'(vecs[v].sel));
          check($sformatf("vec%0d mem_read_rst c1", v), 32'(mem_read_rst), 32'd1);
        end
        if (c == 2) check($sformatf("vec%0d mem_read_en c2", v), 32'(mem_read_en), 32'd1);
        if (note_out != 5'd0) begin
          if (first == 0) begin
            first = c;
            seen  = note_out;
          end
          len++;
        end
        if (done) begin
          if (done_at == 0) done_at = c;
          n_done++;
        end
        @(negedge clk);
      end
      check($sformatf("vec%0d note", v), 32'(seen), 32'(vecs[v].exp_note));
      check($sformatf("vec%0d first cycle", v), 32'(first), 32'(vecs[v].exp_first));
      check($sformatf("vec%0d note length", v), 32'(len), 32'(vecs[v].exp_len));
      check($sformatf("vec%0d done cycle", v), 32'(done_at), 32'(vecs[v].exp_done));
      check($sformatf("vec%0d done count", v), 32'(n_done), 32'd1);
      check($sformatf("vec%0d busy after", v), 32'(busy), 32'd0);
    end

    // Pause for 5 cycles mid-note stretches a 1-beat note to 9 cycles.
    songs[0][0] = 8'h03; songs[0][1] = 8'h1F; mem_lat = 1;
    pulse_start(2'd0);
    len = 0; pc = 0; pset = 1'b0;
    for (int c = 0; c < 60; c++) begin
      if (note_out == 5'd3) len++;
      if (pause) begin
        pc++;
        if (pc == 5) pause = 1'b0;
      end else if (len == 2 && !pset) begin
        pause = 1'b1;
        pset  = 1'b1;
      end
      @(negedge clk);
    end
    pause = 1'b0;
    check("pause note length", 32'(len), 32'd9);

    // Memory never answers: timeout after 8 WAIT cycles, sticky until next start.
    songs[1][0] = 8'h1F;
    mem_lat = 0;
    pulse_start(2'd1);
    for (int c = 1; c <= 20; c++) begin
      if (c == 10) begin
        check("timeout busy c10", 32'(busy), 32'd1);
        check("timeout err c10", 32'(timeout_err), 32'd0);
      end
      if (c == 11) begin
        check("timeout err c11", 32'(timeout_err), 32'd1);
        check("timeout busy c11", 32'(busy), 32'd0);
        check("timeout note c11", 32'(note_out), 32'd0);
      end
      @(negedge clk);
    end
    check("timeout err sticky", 32'(timeout_err), 32'd1);
    mem_lat = 1;
    pulse_start(2'd1);
    check("timeout cleared by start", 32'(timeout_err), 32'd0);
    n_done = 0;
    for (int c = 0; c < 20; c++) begin
      if (done) n_done++;
      @(negedge clk);
    end
    check("after timeout done count", 32'(n_done), 32'd1);

    // Ready on the last allowed WAIT cycle is accepted; one cycle later is too late.
    mem_lat = 8;
    pulse_start(2'd1);
    n_done = 0; to_seen = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (done) n_done++;
      if (timeout_err) to_seen = 1'b1;
      @(negedge clk);
    end
    check("lat8 no timeout", 32'(to_seen), 32'd0);
    check("lat8 done", 32'(n_done), 32'd1);
    mem_lat = 9;
    pulse_start(2'd1);
    n_done = 0;
    for (int c = 0; c < 30; c++) begin
      if (done) n_done++;
      @(negedge clk);
    end
    check("lat9 timeout", 32'(timeout_err), 32'd1);
    check("lat9 no done", 32'(n_done), 32'd0);

    // Stop mid-note; start while busy is ignored; stop beats start in IDLE.
    songs[3][0] = 8'hE5; songs[3][1] = 8'h1F; mem_lat = 1;
    pulse_start(2'd3);
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      if (note_out == 5'd5) found = 1'b1;
      else @(negedge clk);
    end
    check("stop test note seen", 32'(found), 32'd1);
    repeat (3) @(negedge clk);
    pulse_start(2'd1);
    check("busy start mem_select", 32'(mem_select), 32'd3);
    check("busy start note held", 32'(note_out), 32'd5);
    check("busy start no rewind", 32'(mem_read_rst), 32'd0);
    pulse_stop();
    check("stop note_out", 32'(note_out), 32'd0);
    check("stop busy", 32'(busy), 32'd0);
    check("stop done", 32'(done), 32'd0);
    n_done = 0; busy_low = 0;
    for (int c = 0; c < 40; c++) begin
      if (done) n_done++;
      if (!busy) busy_low++;
      @(negedge clk);
    end
    check("stop no later done", 32'(n_done), 32'd0);
    check("stop stays idle", 32'(busy_low), 32'd40);
    stop = 1'b1;
    pulse_start(2'd2);
    check("stop over start busy", 32'(busy), 32'd0);
    check("stop over start rewind", 32'(mem_read_rst), 32'd0);
    check("stop over start select", 32'(mem_select), 32'd3);
    stop = 1'b0;
    @(negedge clk);

`ifdef PLAYBACK_LOOP_EN
    songs[2][0] = 8'h02; songs[2][1] = 8'h1F; mem_lat = 1;
    loop = 1'b1;
    pulse_start(2'd2);
    n_done = 0; busy_low = 0;
    for (int c = 1; c <= 80; c++) begin
      if (done) begin
        n_done++;
        check($sformatf("loop pass%0d busy", n_done), 32'(busy), 32'd1);
        check($sformatf("loop pass%0d rewind", n_done), 32'(mem_read_rst), 32'd1);
      end
      if (!busy) busy_low++;
      @(negedge clk);
    end
    check("loop done count", 32'(n_done), 32'd6);
    check("loop busy never low", 32'(busy_low), 32'd0);
    loop = 1'b0;
    pulse_stop();
    @(negedge clk);
`endif

    // Random songs against the timeline model.
    for (int it = 0; it < 25; it++) begin
      int sel, n, lat;
      sel = $urandom_range(0, 3);
      n   = $urandom_range(0, 4);
      lat = $urandom_range(1, 3);
      for (int j = 0; j < n; j++)
        songs[sel][j] = {3'($urandom_range(0, 7)), 5'($urandom_range(0, 30))};
      songs[sel][n] = 8'h1F;
      mem_lat = lat;
      build_expected(sel, n, lat);
      pulse_start(2'(sel));
      bad = 1'b0;
      for (int i = 0; i < exp_q.size(); i++) begin
        obs = obs_t'{note_out, busy, done, mem_read_rst, mem_read_en};
        check($sformatf("rand%0d cyc%0d {note,busy,done,rrst,ren}", it, i + 1),
              32'(obs), 32'(exp_q[i]));
        if (obs !== exp_q[i]) begin
          bad = 1'b1;
          break;
        end
        @(negedge clk);
      end
      if (bad) begin
        pulse_stop();
        repeat (12) @(negedge clk);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
